// File: rtl/mem_responder_if.sv
// ----------------------------------------------------------------------------
// mem_responder_if
//   Async-SRAM style bus between an initiator (master) and mem_responder
//   (slave). All control strobes are active-low.
//
//   Mem_CE     : chip enable
//   Mem_OE     : output enable (read request)
//   Mem_WE     : write enable
//   Mem_UB     : upper byte lane enable (bits 15:8)
//   Mem_LB     : lower byte lane enable (bits 7:0)
//   ADDR       : 20-bit word address
//   Data_in    : write data from initiator
//   Data_out   : registered read data from responder
//   Data_valid : Data_out holds valid read data
//   Conflict   : OE and WE were both low under CE low on the previous cycle
// ----------------------------------------------------------------------------
interface mem_responder_if;
  logic        Mem_CE;
  logic        Mem_OE;
  logic        Mem_WE;
  logic        Mem_UB;
  logic        Mem_LB;
  logic [19:0] ADDR;
  logic [15:0] Data_in;
  logic [15:0] Data_out;
  logic        Data_valid;
  logic        Conflict;

  modport master (
    output Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB, ADDR, Data_in,
    input  Data_out, Data_valid, Conflict
  );

  modport slave (
    input  Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB, ADDR, Data_in,
    output Data_out, Data_valid, Conflict
  );
endinterface

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
//   1024 x 16 memory model answering an async-SRAM style bus, sampled on the
//   rising edge of Clk. Reads present data one cycle after OE is first seen
//   low (state RD1) and hold it in RD2 while the address is stable. Writes
//   commit once per WE-low pulse, at the edge that enters WR, with per-byte
//   lane enables. Address bits 19:10 are ignored, so addresses alias mod 1024.
//
//   Ports:
//     Clk         : sole clock, rising edge
//     Reset       : asynchronous, active-low
//     bus         : mem_responder_if.slave (controls, address, data, flags)
//     Read_count  : reads started, saturating     (MEM_RESP_STATS_EN only)
//     Write_count : writes committed, saturating  (MEM_RESP_STATS_EN only)
//
//   Configuration:
//     MEM_RESP_STATS_EN : when defined, adds the Read_count / Write_count
//                         outputs. Undefined by default.
// ----------------------------------------------------------------------------
module mem_responder (
  input  logic           Clk,
  input  logic           Reset,
  mem_responder_if.slave bus
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [15:0]    Read_count,
  output logic [15:0]    Write_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD1,
    ST_RD2,
    ST_WR
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        conflict_q, conflict_d;
  // A read may only start once OE has been seen high since reset, so an OE
  // held low across a reset does not restart the interrupted read.
  logic        armed_q, armed_d;

  logic        rd_load;
  logic        rd_start;
  logic        wr_en;
  logic        conflict_req;
  logic [15:0] rd_word;

  logic [15:0] mem [1024];

  assign conflict_req = !bus.Mem_CE && !bus.Mem_OE && !bus.Mem_WE;
  assign rd_word      = mem[bus.ADDR[9:0]];

  // --------------------------------------------------------------------------
  // Next-state and datapath decode
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    conflict_d = 1'b0;
    armed_d    = armed_q | bus.Mem_OE;
    rd_load    = 1'b0;
    rd_start   = 1'b0;
    wr_en      = 1'b0;

    if (bus.Mem_CE) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (conflict_req) begin
            conflict_d = 1'b1;
          end else if (!bus.Mem_OE && armed_q) begin
            state_d  = ST_RD1;
            rd_load  = 1'b1;
            rd_start = 1'b1;
          end else if (!bus.Mem_WE && bus.Mem_OE) begin
            state_d = ST_WR;
            wr_en   = 1'b1;
          end
        end

        ST_RD1, ST_RD2: begin
          if (conflict_req) begin
            state_d    = ST_IDLE;
            conflict_d = 1'b1;
          end else if (bus.Mem_OE) begin
            state_d = ST_IDLE;
          end else if (bus.ADDR != addr_q) begin
            state_d = ST_RD1;
            rd_load = 1'b1;
          end else begin
            state_d = ST_RD2;
          end
        end

        ST_WR: begin
          // One commit per pulse: later edges with WE low write nothing.
          if (bus.Mem_WE) begin
            state_d = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    // A byte whose lane enable is high reads back as zero.
    if (rd_load) begin
      addr_d = bus.ADDR;
      data_d = {bus.Mem_UB ? 8'h00 : rd_word[15:8],
                bus.Mem_LB ? 8'h00 : rd_word[7:0]};
    end
  end

  // --------------------------------------------------------------------------
  // Control and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      conflict_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      conflict_q <= conflict_d;
      armed_q    <= armed_d;
    end
  end

  // --------------------------------------------------------------------------
  // Storage array
  // --------------------------------------------------------------------------
  // NOTE: the array has no reset; contents survive Reset. The Reset term only
  // blocks a write whose edge lands while Reset is held low.
  always_ff @(posedge Clk) begin
    if (wr_en && Reset) begin
      if (!bus.Mem_UB) mem[bus.ADDR[9:0]][15:8] <= bus.Data_in[15:8];
      if (!bus.Mem_LB) mem[bus.ADDR[9:0]][7:0]  <= bus.Data_in[7:0];
    end
  end

  assign bus.Data_out   = data_q;
  assign bus.Data_valid = (state_q == ST_RD1) || (state_q == ST_RD2);
  assign bus.Conflict   = conflict_q;

`ifdef MEM_RESP_STATS_EN
  // --------------------------------------------------------------------------
  // Activity counters, saturating at all-ones
  // --------------------------------------------------------------------------
  logic [15:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_start && (rd_cnt_q != 16'hFFFF)) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (wr_en    && (wr_cnt_q != 16'hFFFF)) wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign Read_count  = rd_cnt_q;
  assign Write_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_responder
//   Directed bench for mem_responder. Inputs are driven 1 time unit after the
//   rising edge and outputs are sampled at that same point, so each sample
//   shows the state produced by the preceding edge.
// ----------------------------------------------------------------------------
module tb_mem_responder;

  logic Clk;
  logic Reset;

  mem_responder_if bus ();

`ifdef MEM_RESP_STATS_EN
  logic [15:0] read_count;
  logic [15:0] write_count;
`endif

  mem_responder dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
`ifdef MEM_RESP_STATS_EN
    ,
    .Read_count  (read_count),
    .Write_count (write_count)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_rd   = 0;
  int exp_wr   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_bus(input logic ce, input logic oe, input logic we,
                         input logic ub, input logic lb,
                         input logic [19:0] addr, input logic [15:0] din);
    bus.Mem_CE  = ce;
    bus.Mem_OE  = oe;
    bus.Mem_WE  = we;
    bus.Mem_UB  = ub;
    bus.Mem_LB  = lb;
    bus.ADDR    = addr;
    bus.Data_in = din;
  endtask

  task automatic idle();
    set_bus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 20'h0, 16'h0);
    tick();
  endtask

  task automatic write_word(input logic [19:0] addr, input logic [15:0] data,
                            input logic ub, input logic lb);
    set_bus(1'b0, 1'b1, 1'b0, ub, lb, addr, data);
    tick();
    exp_wr++;
    idle();
  endtask

  // Drives OE low and checks the first valid cycle (state RD1).
  task automatic read_first(input string tag, input logic [19:0] addr,
                            input logic ub, input logic lb,
                            input logic [15:0] exp);
    set_bus(1'b0, 1'b0, 1'b1, ub, lb, addr, 16'h0);
    tick();
    exp_rd++;
    check({tag, "_valid"}, {31'd0, bus.Data_valid}, 32'd1);
    check({tag, "_data"},  {16'd0, bus.Data_out},   {16'd0, exp});
  endtask

  initial begin
    Reset = 1'b0;
    set_bus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 20'h0, 16'h0);
    #1;
    check("reset_data",     {16'd0, bus.Data_out},   32'h0);
    check("reset_valid",    {31'd0, bus.Data_valid}, 32'd0);
    check("reset_conflict", {31'd0, bus.Conflict},   32'd0);
    #11 Reset = 1'b1;
    tick();

    // Basic write then a two-cycle read.
    write_word(20'h00010, 16'hBEEF, 1'b0, 1'b0);
    set_bus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00010, 16'h0);
    check("rd_first_cycle_valid", {31'd0, bus.Data_valid}, 32'd0);
    tick();
    exp_rd++;
    check("rd1_valid", {31'd0, bus.Data_valid}, 32'd1);
    check("rd1_data",  {16'd0, bus.Data_out},   32'hBEEF);
    tick();
    check("rd2_valid", {31'd0, bus.Data_valid}, 32'd1);
    check("rd2_data",  {16'd0, bus.Data_out},   32'hBEEF);
    idle();
    check("idle_valid", {31'd0, bus.Data_valid}, 32'd0);
    check("idle_hold",  {16'd0, bus.Data_out},   32'hBEEF);

    // Byte-lane writes and masked reads.
    write_word(20'h00020, 16'h1234, 1'b0, 1'b0);
    write_word(20'h00020, 16'hABCD, 1'b1, 1'b0);
    read_first("lane_wr", 20'h00020, 1'b0, 1'b0, 16'h12CD);
    idle();
    read_first("lane_rd", 20'h00020, 1'b0, 1'b1, 16'h1200);
    idle();

    // Address wrap: 0x00400 aliases 0x00000.
    write_word(20'h00400, 16'h5555, 1'b0, 1'b0);
    read_first("wrap", 20'h00000, 1'b0, 1'b0, 16'h5555);
    idle();

    // Address change while reading reloads from the new word.
    read_first("chg_a", 20'h00010, 1'b0, 1'b0, 16'hBEEF);
    tick();
    bus.ADDR = 20'h00020;
    tick();
    check("chg_valid", {31'd0, bus.Data_valid}, 32'd1);
    check("chg_data",  {16'd0, bus.Data_out},   32'h12CD);

    // CE high drops the read even with OE still low.
    bus.Mem_CE = 1'b1;
    tick();
    check("ce_abort_valid", {31'd0, bus.Data_valid}, 32'd0);
    idle();

    // Conflict: OE and WE both low.
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00010, 16'hFFFF);
    tick();
    check("conflict_flag",  {31'd0, bus.Conflict},   32'd1);
    check("conflict_valid", {31'd0, bus.Data_valid}, 32'd0);
    idle();
    check("conflict_clear", {31'd0, bus.Conflict},   32'd0);
    read_first("conflict_mem", 20'h00010, 1'b0, 1'b0, 16'hBEEF);
    idle();

    // WE held low four cycles: only the first data word commits.
    for (int i = 1; i <= 4; i++) begin
      set_bus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00030, 16'(i));
      tick();
    end
    exp_wr++;
    idle();
    read_first("we_hold", 20'h00030, 1'b0, 1'b0, 16'h0001);

    // Reset during RD2: outputs clear without a clock edge.
    tick();
    check("pre_reset_valid", {31'd0, bus.Data_valid}, 32'd1);
    #2 Reset = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, bus.Data_valid}, 32'd0);
    check("async_rst_data",  {16'd0, bus.Data_out},   32'h0);
`ifdef MEM_RESP_STATS_EN
    check("rst_read_count",  {16'd0, read_count},  32'h0);
    check("rst_write_count", {16'd0, write_count}, 32'h0);
    exp_rd = 0;
    exp_wr = 0;
`endif
    #3 Reset = 1'b1;
    tick();
    check("no_restart_valid", {31'd0, bus.Data_valid}, 32'd0);
    bus.Mem_OE = 1'b1;
    tick();
    read_first("post_rst", 20'h00030, 1'b0, 1'b0, 16'h0001);
    idle();

`ifdef MEM_RESP_STATS_EN
    write_word(20'h00040, 16'h0042, 1'b0, 1'b0);
    check("read_count",  {16'd0, read_count},  32'(exp_rd));
    check("write_count", {16'd0, write_count}, 32'(exp_wr));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have port Clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port Reset, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port Mem_CE, input, 1, chip enable, active-low.
REQ-004 SHALL have port Mem_OE, input, 1, output enable (read request), active-low.
REQ-005 SHALL have port Mem_WE, input, 1, write enable, active-low.
REQ-006 SHALL have port Mem_UB, input, 1, upper byte lane enable (bits 15:8), active-low.
REQ-007 SHALL have port Mem_LB, input, 1, lower byte lane enable (bits 7:0), active-low.
REQ-008 SHALL have port ADDR, input, 20, word address.
REQ-009 SHALL have port Data_in, input, 16, write data from initiator.
REQ-010 SHALL have port Data_out, output, 16, registered read data.
REQ-011 SHALL have port Data_valid, output, 1, Data_out holds valid read data.
REQ-012 SHALL have port Conflict, output, 1, registered flag: OE and WE both low under CE low last cycle.

Function
REQ-013 SHALL store 1024 x 16-bit words indexed by ADDR[9:0]; ADDR[19:10] ignored, so addresses wrap modulo 1024 (0x00400 aliases 0x00000).
REQ-014 SHALL implement FSM states IDLE, RD1, RD2, WR.
REQ-015 "Request sampled" means inputs as seen at the rising edge; Mem_CE high forces every state to IDLE, Data_valid 0, at the next edge.
REQ-016 IDLE: CE=0, OE=0, WE=1 -> RD1, latch ADDR, load Data_out with mem[ADDR] (lane-masked).
REQ-017 IDLE: CE=0, WE=0, OE=1 -> WR, commit Data_in to mem[ADDR] at that same edge, upper byte only if UB=0, lower byte only if LB=0.
REQ-018 IDLE/RD1/RD2: CE=0, OE=0, WE=0 -> IDLE, no read, no write, Conflict=1 for one cycle; Conflict=0 otherwise.
REQ-019 Read latency: Data_valid=1 and Data_out valid during the second cycle of a continuous OE-low assertion (state RD1), and in RD2.
REQ-020 RD1: OE still low, ADDR unchanged -> RD2; ADDR changed -> RD1 reloading from new address, Data_valid stays 1 with new data; OE high -> IDLE.
REQ-021 RD2: same transitions as RD1 (ADDR changed -> RD1); Data_out held stable while ADDR unchanged.
REQ-022 Read lane masking: byte whose enable (UB/LB) is high at load reads as 0x00.
REQ-023 WR: exactly one commit per WE-low pulse; remain in WR while WE low (no further writes, even if ADDR/Data_in change); WE high -> IDLE.
REQ-024 Read-after-write to same address SHALL return the newly written data; write and read never occur at the same edge.
REQ-025 Data_valid=0 in IDLE and WR; Data_out retains last value when Data_valid=0.

Reset
REQ-026 Reset low SHALL immediately force state IDLE, Data_out=16'h0000, Data_valid=0, Conflict=0.
REQ-027 Memory contents SHALL NOT be reset; a write whose edge coincides with Reset low SHALL NOT commit.
REQ-028 Reset asserted mid-read SHALL drop Data_valid asynchronously; after release, a new OE-low pulse is required to read.

Configuration
REQ-029 Macro MEM_RESP_STATS_EN defined: adds outputs Read_count[15:0] and Write_count[15:0], incremented on each IDLE->RD1 entry and each write commit, saturating at 16'hFFFF, cleared by Reset.
REQ-030 Macro undefined: those ports and counters do not exist; all other behaviour identical.

Verification
REQ-031 Write 16'hBEEF to 0x00010 (UB=LB=0), then OE low 2 cycles at 0x00010 -> Data_valid=1 second cycle, Data_out=16'hBEEF.
REQ-032 Preload 0x00020=16'h1234, write 16'hABCD with UB=1, LB=0 -> read returns 16'h12CD; read with LB=1 -> 16'h1200.
REQ-033 Write 16'h5555 to 0x00400, read 0x00000 -> 16'h5555 (wrap).
REQ-034 CE=0, OE=0, WE=0 one cycle -> Conflict=1 next cycle, memory unchanged, Data_valid=0.
REQ-035 WE held low 4 cycles while Data_in changes 1,2,3,4 -> memory holds 1; with MEM_RESP_STATS_EN Write_count=1.
REQ-036 Reset low during RD2 -> Data_valid=0 and Data_out=0 without a clock edge; memory contents intact on later read.
